// File: rtl/axi_pkg.sv
// Shared AXI constants, refill FSM state encoding and the beat-count helper
// used by the I-cache refill master.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } t_refill_state;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic int calc_beats(input int block_width, input int data_width);
        return block_width / data_width;
    endfunction

endpackage

// File: rtl/refill_beat_assembler.sv
// Collects R-channel beats into one cache block and flags any malformed burst
// (error response, early rlast, or beats past the end of the block).
module refill_beat_assembler
    import axi_pkg::*;
#(
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      clk_i,
    input  logic                      arst_i,
    input  logic                      clr_i,
    input  logic                      beat_i,
    input  logic [AXI_DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rlast_i,
    output logic [BLOCK_WIDTH-1:0]    block_o,
    output logic                      err_next_o
);

    localparam int BEATS = calc_beats(BLOCK_WIDTH, AXI_DATA_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   err_q, err_d;
    logic [BLOCK_WIDTH-1:0] block_q, block_d;
    logic                   at_last_s;
    logic                   beat_err_s;

    // rlast must coincide exactly with the final slot; a mismatch either way
    // is a short or long burst. Once the last slot is filled, further beats
    // are drained without touching the block.
    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        block_d    = block_q;
        at_last_s  = (cnt_q == CNT_LAST);
        beat_err_s = (rresp_i != AXI_RESP_OKAY) || (rlast_i != at_last_s);
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
            err_d = 1'b0;
        end else if (beat_i) begin
            err_d = err_q | beat_err_s;
            if (!ovf_q) begin
                block_d[int'(cnt_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = rdata_i;
            end else begin
                block_d = block_q;
            end
            if (at_last_s) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers for counter, overflow, sticky error and block data.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            block_q <= {BLOCK_WIDTH{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            block_q <= block_d;
        end
    end

    assign block_o    = block_q;
    assign err_next_o = err_q | (beat_i & beat_err_s);

endmodule

// File: rtl/icache_refill_unit.sv
// AXI4 read-burst master refilling one I-cache block per miss: one INCR burst
// out, beats assembled into a line, single-cycle write strobe or error pulse.
module icache_refill_unit
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int BLOCK_WIDTH    = 512,
    parameter int AXI_DATA_WIDTH = 64
) (
    input  logic                      i_clk,
    input  logic                      i_arst,
    input  logic                      i_start,
    input  logic [ADDR_WIDTH-1:0]     i_addr,
    output logic                      o_busy,
    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    output logic                      o_instr_we,
    output logic [BLOCK_WIDTH-1:0]    o_instr_block,
    output logic                      o_error
);

    localparam int BEATS       = calc_beats(BLOCK_WIDTH, AXI_DATA_WIDTH);
    localparam int OFFSET_BITS = $clog2(BLOCK_WIDTH / 8);
    localparam logic [7:0] AR_LEN  = 8'(BEATS - 1);
    localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
        {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    t_refill_state         state_q;
    logic [ADDR_WIDTH-1:0] araddr_q;
    logic                  arvalid_q;
    logic                  rready_q;
    logic                  we_q;
    logic                  error_q;
    logic                  busy_q;
    logic                  beat_s;
    logic                  clr_s;
    logic                  err_next_s;

    assign beat_s = i_rvalid & rready_q;
    assign clr_s  = (state_q == DONE);

    refill_beat_assembler #(
        .BLOCK_WIDTH    (BLOCK_WIDTH),
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH)
    ) u_assembler (
        .clk_i      (i_clk),
        .arst_i     (i_arst),
        .clr_i      (clr_s),
        .beat_i     (beat_s),
        .rdata_i    (i_rdata),
        .rresp_i    (i_rresp),
        .rlast_i    (i_rlast),
        .block_o    (o_instr_block),
        .err_next_o (err_next_s)
    );

    // Refill FSM; every handshake and status output is a registered flop so
    // the DONE-cycle strobe already reflects the error status of the last beat.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q   <= IDLE;
            araddr_q  <= {ADDR_WIDTH{1'b0}};
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            we_q      <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we_q    <= 1'b0;
                    error_q <= 1'b0;
                    if (i_start) begin
                        araddr_q  <= i_addr & BLOCK_MASK;
                        arvalid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (i_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_s && i_rlast) begin
                        rready_q <= 1'b0;
                        we_q     <= ~err_next_s;
                        error_q  <= err_next_s;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    we_q    <= 1'b0;
                    error_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    we_q      <= 1'b0;
                    error_q   <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign o_busy     = busy_q;
    assign o_arvalid  = arvalid_q;
    assign o_araddr   = araddr_q;
    assign o_arlen    = AR_LEN;
    assign o_arsize   = AR_SIZE;
    assign o_arburst  = AXI_BURST_INCR;
    assign o_rready   = rready_q;
    assign o_instr_we = we_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: nominal refill, AR/R back-pressure,
// error response, short/long bursts and reset mid-burst.
module tb_icache_refill_unit;

    logic         clk;
    logic         i_arst;
    logic         i_start;
    logic [63:0]  i_addr;
    logic         o_busy;
    logic         o_arvalid;
    logic         i_arready;
    logic [63:0]  o_araddr;
    logic [7:0]   o_arlen;
    logic [2:0]   o_arsize;
    logic [1:0]   o_arburst;
    logic         i_rvalid;
    logic         o_rready;
    logic [63:0]  i_rdata;
    logic [1:0]   i_rresp;
    logic         i_rlast;
    logic         o_instr_we;
    logic [511:0] o_instr_block;
    logic         o_error;

    int checks   = 0;
    int failures = 0;
    int we_cnt   = 0;
    int err_cnt  = 0;
    int ar_cnt   = 0;
    int ar_base;
    logic [511:0] exp_blk;

    icache_refill_unit dut (
        .i_clk         (clk),
        .i_arst        (i_arst),
        .i_start       (i_start),
        .i_addr        (i_addr),
        .o_busy        (o_busy),
        .o_arvalid     (o_arvalid),
        .i_arready     (i_arready),
        .o_araddr      (o_araddr),
        .o_arlen       (o_arlen),
        .o_arsize      (o_arsize),
        .o_arburst     (o_arburst),
        .i_rvalid      (i_rvalid),
        .o_rready      (o_rready),
        .i_rdata       (i_rdata),
        .i_rresp       (i_rresp),
        .i_rlast       (i_rlast),
        .o_instr_we    (o_instr_we),
        .o_instr_block (o_instr_block),
        .o_error       (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse and AR-handshake counters sampled at the active edge.
    always @(posedge clk) begin
        if (!i_arst) begin
            if (o_instr_we)            we_cnt  <= we_cnt + 1;
            if (o_error)               err_cnt <= err_cnt + 1;
            if (o_arvalid && i_arready) ar_cnt <= ar_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [511:0] model_block(input logic [63:0] base);
        logic [511:0] b;
        b = 512'd0;
        for (int k = 0; k < 8; k++) b[k*64 +: 64] = base + 64'(k);
        return b;
    endfunction

    // Drives one refill and returns in the cycle right after the rlast beat.
    task automatic refill(input logic [63:0] addr, input logic [63:0] base,
                          input int n_beats, input int last_beat, input int bad_beat,
                          input int ar_stall, input bit gaps, input bit hold_start);
        i_start   = 1'b1;
        i_addr    = addr;
        i_arready = 1'b0;
        step();
        if (!hold_start) i_start = 1'b0;
        for (int s = 0; s < ar_stall; s++) begin
            chk("stall_arvalid", 512'(o_arvalid), 512'd1);
            chk("stall_araddr", 512'(o_araddr), 512'(addr & ~64'h3F));
            chk("stall_rready", 512'(o_rready), 512'd0);
            chk("stall_busy", 512'(o_busy), 512'd1);
            step();
        end
        chk("arvalid", 512'(o_arvalid), 512'd1);
        chk("araddr", 512'(o_araddr), 512'(addr & ~64'h3F));
        chk("arlen", 512'(o_arlen), 512'd7);
        chk("arsize", 512'(o_arsize), 512'd3);
        chk("arburst", 512'(o_arburst), 512'd1);
        i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        chk("data_rready", 512'(o_rready), 512'd1);
        chk("data_arvalid", 512'(o_arvalid), 512'd0);
        for (int b = 0; b < n_beats; b++) begin
            if (gaps && b > 0) begin
                i_rvalid = 1'b0;
                step();
                step();
            end
            i_rvalid = 1'b1;
            i_rdata  = base + 64'(b);
            i_rlast  = (b == last_beat);
            i_rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
            step();
        end
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = 2'b00;
        i_start  = 1'b0;
    endtask

    initial begin
        i_arst = 1'b1; i_start = 1'b0; i_addr = 64'd0; i_arready = 1'b0;
        i_rvalid = 1'b0; i_rdata = 64'd0; i_rresp = 2'b00; i_rlast = 1'b0;
        step();
        step();
        chk("rst_arvalid", 512'(o_arvalid), 512'd0);
        chk("rst_rready", 512'(o_rready), 512'd0);
        chk("rst_we", 512'(o_instr_we), 512'd0);
        chk("rst_error", 512'(o_error), 512'd0);
        chk("rst_busy", 512'(o_busy), 512'd0);
        chk("rst_araddr", 512'(o_araddr), 512'd0);
        i_arst = 1'b0;
        step();

        // Nominal refill: o_instr_we lands ten cycles after i_start.
        refill(64'h0000_0000_8000_0124, 64'd0, 8, 7, -1, 0, 1'b0, 1'b0);
        exp_blk = model_block(64'd0);
        chk("nom_we", 512'(o_instr_we), 512'd1);
        chk("nom_error", 512'(o_error), 512'd0);
        chk("nom_low", 512'(o_instr_block[63:0]), 512'd0);
        chk("nom_high", 512'(o_instr_block[511:448]), 512'd7);
        chk("nom_block", o_instr_block, exp_blk);
        chk("nom_busy_done", 512'(o_busy), 512'd1);
        step();
        chk("nom_we_after", 512'(o_instr_we), 512'd0);
        chk("nom_idle_busy", 512'(o_busy), 512'd0);
        chk("nom_we_count", 512'(we_cnt), 512'd1);
        chk("nom_block_hold", o_instr_block, exp_blk);

        // AR back-pressure for five cycles.
        refill(64'h0000_0012_3456_7FFF, 64'h100, 8, 7, -1, 5, 1'b0, 1'b0);
        chk("arbp_we", 512'(o_instr_we), 512'd1);
        chk("arbp_block", o_instr_block, model_block(64'h100));
        step();

        // R back-pressure with 1,0,0,1 valid pattern.
        refill(64'h0000_0000_8000_0124, 64'd0, 8, 7, -1, 0, 1'b1, 1'b0);
        chk("rbp_we", 512'(o_instr_we), 512'd1);
        chk("rbp_block", o_instr_block, model_block(64'd0));
        step();
        chk("rbp_we_count", 512'(we_cnt), 512'd3);

        // SLVERR on beat 3, then a clean refill.
        refill(64'h0000_0000_4000_0040, 64'h200, 8, 7, 3, 0, 1'b0, 1'b0);
        chk("resp_error", 512'(o_error), 512'd1);
        chk("resp_we", 512'(o_instr_we), 512'd0);
        step();
        chk("resp_err_off", 512'(o_error), 512'd0);
        chk("resp_counts", 512'({we_cnt, err_cnt}), 512'({32'd3, 32'd1}));
        refill(64'h0000_0000_4000_0040, 64'h300, 8, 7, -1, 0, 1'b0, 1'b0);
        chk("resp_next_we", 512'(o_instr_we), 512'd1);
        chk("resp_next_block", o_instr_block, model_block(64'h300));
        step();

        // Short burst: rlast on beat 5.
        refill(64'h0000_0000_4000_0080, 64'h400, 6, 5, -1, 0, 1'b0, 1'b0);
        chk("short_error", 512'(o_error), 512'd1);
        chk("short_we", 512'(o_instr_we), 512'd0);
        step();
        chk("short_idle", 512'(o_busy), 512'd0);

        // Long burst: rlast on beat 9.
        refill(64'h0000_0000_4000_00C0, 64'h500, 10, 9, -1, 0, 1'b0, 1'b0);
        chk("long_error", 512'(o_error), 512'd1);
        chk("long_we", 512'(o_instr_we), 512'd0);
        step();
        chk("long_idle", 512'(o_busy), 512'd0);
        chk("long_counts", 512'({we_cnt, err_cnt}), 512'({32'd4, 32'd3}));

        // Reset after beat 4 of a burst.
        i_start = 1'b1; i_addr = 64'h0000_0000_9000_0000;
        step();
        i_start = 1'b0; i_arready = 1'b1;
        step();
        i_arready = 1'b0;
        for (int b = 0; b < 5; b++) begin
            i_rvalid = 1'b1; i_rdata = 64'hDEAD_0000 + 64'(b); i_rlast = 1'b0;
            step();
        end
        i_rvalid = 1'b0;
        i_arst = 1'b1;
        step();
        chk("mid_arvalid", 512'(o_arvalid), 512'd0);
        chk("mid_rready", 512'(o_rready), 512'd0);
        chk("mid_we", 512'(o_instr_we), 512'd0);
        chk("mid_error", 512'(o_error), 512'd0);
        chk("mid_busy", 512'(o_busy), 512'd0);
        chk("mid_araddr", 512'(o_araddr), 512'd0);
        chk("mid_block", o_instr_block, 512'd0);
        i_arst = 1'b0;
        ar_base = ar_cnt;
        refill(64'h0000_0000_9000_0010, 64'h600, 8, 7, -1, 2, 1'b0, 1'b1);
        chk("post_we", 512'(o_instr_we), 512'd1);
        chk("post_block", o_instr_block, model_block(64'h600));
        step();
        chk("post_single_ar", 512'(ar_cnt - ar_base), 512'd1);
        chk("post_idle", 512'(o_busy), 512'd0);
        step();
        chk("post_no_restart", 512'(o_arvalid), 512'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
AXI4 read-burst master that refills one instruction-cache block on an I-cache miss.
- Accepts the block-aligned miss address from the fetch stage and issues one INCR burst.
- Assembles the returned beats into a BLOCK_WIDTH line.
- Presents the line to the I-cache with a single-cycle write enable.
- Sits between the fetch stage and the memory-side AXI interconnect; the memory controller FSM drives i_start.

Parameters:
ADDR_WIDTH, 64, address width.
BLOCK_WIDTH, 512, cache block width in bits.
AXI_DATA_WIDTH, 64, AXI R-channel data width; BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH = 8.

Ports:
i_clk  in  1  clock.
i_arst  in  1  reset; synchronous, active-high (sampled on rising i_clk).
i_start  in  1  refill request; honoured only in IDLE.
i_addr  in  ADDR_WIDTH  miss address (fetch-side read address).
o_busy  out  1  high in every state except IDLE.
o_arvalid  out  1  AXI AR valid.
i_arready  in  1  AXI AR ready.
o_araddr  out  ADDR_WIDTH  burst address.
o_arlen  out  8  burst length minus one.
o_arsize  out  3  beat size code.
o_arburst  out  2  burst type.
i_rvalid  in  1  AXI R valid.
o_rready  out  1  AXI R ready.
i_rdata  in  AXI_DATA_WIDTH  beat data.
i_rresp  in  2  beat response.
i_rlast  in  1  last beat flag.
o_instr_we  out  1  one-cycle block write strobe to the I-cache.
o_instr_block  out  BLOCK_WIDTH  assembled block.
o_error  out  1  one-cycle pulse on a failed refill.

Behaviour:
- Reset: state IDLE; beat counter 0; block register 0; error flag 0.
  - Outputs at reset: o_arvalid=0, o_rready=0, o_instr_we=0, o_error=0, o_busy=0, o_araddr=0.
  - Reset mid-burst aborts immediately to IDLE. The AXI slave is reset on the same reset.
- States and transitions:
  - IDLE: when i_start=1, latch o_araddr = {i_addr[ADDR_WIDTH-1:6], 6'b0} and go to ADDR. i_start in any other state is ignored.
  - ADDR: o_arvalid=1, with o_araddr, o_arlen, o_arsize and o_arburst held stable. Stay until i_arvalid&i_arready handshake completes (o_arvalid&i_arready); then go to DATA. o_arvalid must not drop before the handshake.
  - DATA: o_rready=1.
    - Each handshake (i_rvalid&o_rready) writes i_rdata into block bits [cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], then cnt increments.
    - Beat 0 lands at the lowest bits.
  - On the handshake with i_rlast=1, go to DONE.
- Fixed burst fields: o_arlen=BEATS-1=7; o_arsize=log2(AXI_DATA_WIDTH/8)=3; o_arburst=2'b01 (INCR).
- Error detection: the sticky error flag is set by any of:
  - i_rresp != 2'b00 on any beat;
  - i_rlast=1 with cnt != BEATS-1 (short burst);
  - a handshake at cnt=BEATS-1 with i_rlast=0 (long burst). In this case, keep consuming until i_rlast and discard the extra beats (cnt saturates at BEATS-1 and no write occurs).
- DONE: lasts exactly one cycle, then returns to IDLE.
  - If the error flag is 0: o_instr_we=1 with o_instr_block valid.
  - Otherwise: o_error=1 and o_instr_we=0.
  - The error flag and cnt clear on leaving DONE.
- o_instr_block holds its value after DONE until the next refill writes it. Partial data is never strobed.
- Latency: the earliest possible sequence is i_start at cycle 0, AR handshake at cycle 1, 8 back-to-back beats at cycles 2-9, and o_instr_we at cycle 10.
- Back-pressure: gaps in i_rvalid stall the counter and do not affect ordering.
- A new i_start may be accepted in the cycle after DONE.

Decomposition:
- Shared package axi_pkg:
  - t_refill_state enum (IDLE, ADDR, DATA, DONE);
  - AXI_BURST_INCR=2'b01;
  - AXI_RESP_OKAY=2'b00;
  - function to compute BEATS.
- One sub-module, refill_beat_assembler: beat counter, block shift/index register, last/overflow detection.
- The FSM and AXI handshakes stay in the top module.

Test Plan:
- Nominal refill: reset, then i_start with i_addr=0x8000_0124. Required: o_araddr=0x8000_0100, o_arlen=7, o_arsize=3, o_arburst=1. With beats 0x0..0x7 returned back-to-back (rlast on beat 7), o_instr_we pulses once at cycle 10 with o_instr_block[63:0]=0 and o_instr_block[511:448]=7.
- AR back-pressure: i_arready held 0 for 5 cycles -> o_arvalid stays 1, o_araddr stays stable, no o_rready before the handshake, o_busy=1 throughout.
- R back-pressure: i_rvalid toggling 1,0,0,1... across 8 beats -> block identical to the nominal case, with o_instr_we one cycle after the rlast beat.
- Error response: i_rresp=2'b10 on beat 3, remaining beats OKAY -> o_error pulses once, o_instr_we stays 0, and the next i_start refills normally.
- Short burst: i_rlast asserted on beat 5 -> o_error pulse, no o_instr_we, return to IDLE. Long burst (rlast on beat 9) -> extra beats consumed, o_error pulse.
- Reset mid-burst: assert i_arst after beat 4 -> next cycle IDLE with all outputs at reset values. A new i_start then completes a clean refill, and i_start while busy is ignored (exactly one AR issued).
